sti_sched: RTL and testbench
============================

STI_SCHED -- requirements
Module: sti_sched

Interface
Parameters:
REQ-001 START_TIMEOUT, 15, max cycles from load to so_valid rising before a timeout error is declared.
Ports:
REQ-002 clk  input  1  single clock, all flops rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 en  input  2  requester enable, bit n = requester n participates; sampled only in IDLE.
REQ-005 req  input  2  requester n has a word pending; held until granted.
REQ-006 gnt  output  2  one-cycle accept pulse to requester n; word captured that cycle.
REQ-007 r0_data, r1_data  input  16  requester payload.
REQ-008 r0_cfg, r1_cfg  input  6  {length[1:0], fill, msb, low, end} per word.
REQ-009 load  output  1  one-cycle strobe to the serial transmitter.
REQ-010 pi_data  output  16  registered payload, valid with load.
REQ-011 pi_length, pi_fill, pi_msb, pi_low, pi_end  output  2/1/1/1/1  registered word controls, valid with load.
REQ-012 so_valid  input  1  transmitter serial-valid, high while bits shift.
REQ-013 pixel_finish  input  1  transmitter's memory-write completion flag.
REQ-014 done  output  1  sticky: all enabled streams sent and pixel_finish seen.
REQ-015 err  output  1  sticky: start timeout or bit-count mismatch.

Function
REQ-016 States SHALL be IDLE, GRANT, LOAD, WAIT_START, SHIFT, DRAIN, FINISH.
REQ-017 IDLE -> GRANT when any req&en&~ended bit is set; else stay.
REQ-018 GRANT SHALL pick one requester round-robin (priority to requester not served last; requester 0 after reset), pulse gnt, and capture data/cfg.
REQ-019 Two requests in the same cycle SHALL be served alternately, never both granted in one cycle.
REQ-020 LOAD SHALL assert load for exactly one cycle with pi_* stable from that cycle until the next grant.
REQ-021 pi_end SHALL be 1 only if the word's end bit is 1 and the other requester is disabled or has already transferred its end word.
REQ-022 WAIT_START -> SHIFT on so_valid=1; if so_valid stays 0 for START_TIMEOUT cycles after load, set err and go to IDLE.
REQ-023 SHIFT SHALL count so_valid-high cycles; expected = 8*(pi_length+1) (8/16/24/32).
REQ-024 On so_valid falling, a count different from expected SHALL set err; either way go to IDLE, or to DRAIN if pi_end was 1.
REQ-025 A word with end=1 SHALL set ended[n]; ended requesters are never granted again until reset.
REQ-026 DRAIN -> FINISH on pixel_finish=1; FINISH SHALL set done and hold; no further grants.
REQ-027 Latency: gnt to load = 1 cycle; so_valid falling to next gnt = 2 cycles minimum.
REQ-028 en=0 for both requesters SHALL leave the block in IDLE with all outputs at reset value.
REQ-029 req deasserted before grant SHALL be ignored without error.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, gnt=0, load=0, pi_*=0, done=0, err=0, ended=0, counters=0, round-robin pointer to requester 0.
REQ-031 Reset mid-SHIFT SHALL abort the word; transmitter resynchronisation is the system's responsibility.

Structure
REQ-032 Shared package sti_pkg SHALL hold the state enum, the cfg field offsets, the bit-count function length->8*(length+1) and the START_TIMEOUT default.
REQ-033 One sub-module rr_arb2 (2-way round-robin arbiter with last-served pointer) SHALL be instantiated; everything else stays in sti_sched.

Verification
REQ-034 en=01, r0 sends 16'hA5C3 len=1 end=1, model so_valid high 16 cycles, pixel_finish -> load once, pi_end=1, done=1, err=0.
REQ-035 en=11, both req every cycle, 4 words each len=0 -> gnt order 0,1,0,1,...; pi_end=1 only on the last end word sent.
REQ-036 len=3 but so_valid high 24 cycles -> err=1 after fall, next grant still proceeds.
REQ-037 so_valid never rises after load -> err=1 exactly START_TIMEOUT cycles after load, state IDLE.
REQ-038 reset low during SHIFT of 32-bit word -> all outputs 0 same cycle; after release new request granted to requester 0.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared types and constants for the serial-transmit word scheduler.
package sti_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      LOAD,
      WAIT_START,
      SHIFT,
      DRAIN,
      FINISH
   } state_t;

   localparam int START_TIMEOUT_DEF = 15;

   // cfg word layout: {length[1:0], fill, msb, low, end}
   localparam int CFG_END  = 0;
   localparam int CFG_LOW  = 1;
   localparam int CFG_MSB  = 2;
   localparam int CFG_FILL = 3;
   localparam int CFG_LEN  = 4;

   function automatic logic [5:0] bit_count(input logic [1:0] len);
      return {1'b0, len, 3'b000} + 6'd8;
   endfunction

endpackage

// File: rtl/sti_sched_rr_arb2.sv
// Two-way round-robin arbiter; priority goes to the requester not served last.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] pick
);

   logic last;

   always_comb begin
      pick = req;
      if (req == 2'b11) begin
         pick = last ? 2'b01 : 2'b10;
      end
   end

   // last=1 after reset so requester 0 wins the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= 1'b1;
      end else if (update && (pick != 2'b00)) begin
         last <= pick[1];
      end
   end

endmodule

// File: rtl/sti_sched.sv
// Schedules words from two requesters onto one serial transmitter
// and supervises start timeout, bit count and end-of-stream drain.
module sti_sched
   import sti_pkg::*;
#(
   parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  en,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   input  logic [15:0] r0_data,
   input  logic [15:0] r1_data,
   input  logic [5:0]  r0_cfg,
   input  logic [5:0]  r1_cfg,
   output logic        load,
   output logic [15:0] pi_data,
   output logic [1:0]  pi_length,
   output logic        pi_fill,
   output logic        pi_msb,
   output logic        pi_low,
   output logic        pi_end,
   input  logic        so_valid,
   input  logic        pixel_finish,
   output logic        done,
   output logic        err
);

   localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 1);

   state_t      state;
   logic [1:0]  en_q;
   logic [1:0]  ended;
   logic [1:0]  elig;
   logic [1:0]  pick;
   logic        sel;
   logic        advance;
   logic        other_done;
   logic [15:0] word_data;
   logic [5:0]  word_cfg;
   logic [7:0]  tcnt;
   logic [7:0]  bcnt;

   assign elig      = req & en & ~ended;
   assign advance   = (state == IDLE) && (elig != 2'b00);
   assign word_data = sel ? r1_data : r0_data;
   assign word_cfg  = sel ? r1_cfg : r0_cfg;

   // stream really ends only once the partner is out of the game too
   assign other_done = sel ? (~en_q[0] | ended[0])
                           : (~en_q[1] | ended[1]);

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (elig),
      .update (advance),
      .pick   (pick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gnt       <= 2'b00;
         load      <= 1'b0;
         pi_data   <= 16'h0000;
         pi_length <= 2'b00;
         pi_fill   <= 1'b0;
         pi_msb    <= 1'b0;
         pi_low    <= 1'b0;
         pi_end    <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         ended     <= 2'b00;
         en_q      <= 2'b00;
         sel       <= 1'b0;
         tcnt      <= 8'd0;
         bcnt      <= 8'd0;
      end else begin
         gnt  <= 2'b00;
         load <= 1'b0;
         unique case (state)
            IDLE: begin
               en_q <= en;
               if (advance) begin
                  gnt   <= pick;
                  sel   <= pick[1];
                  state <= GRANT;
               end
            end
            GRANT: begin
               pi_data   <= word_data;
               pi_length <= word_cfg[CFG_LEN +: 2];
               pi_fill   <= word_cfg[CFG_FILL];
               pi_msb    <= word_cfg[CFG_MSB];
               pi_low    <= word_cfg[CFG_LOW];
               pi_end    <= word_cfg[CFG_END] & other_done;
               if (word_cfg[CFG_END]) begin
                  ended[sel] <= 1'b1;
               end
               load  <= 1'b1;
               state <= LOAD;
            end
            LOAD: begin
               tcnt  <= 8'd1;
               state <= WAIT_START;
            end
            WAIT_START: begin
               if (so_valid) begin
                  bcnt  <= 8'd1;
                  state <= SHIFT;
               end else if (tcnt >= TMO_LAST) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            SHIFT: begin
               if (so_valid) begin
                  if (bcnt != 8'hFF) begin
                     bcnt <= bcnt + 8'd1;
                  end
               end else begin
                  if (bcnt != {2'b00, bit_count(pi_length)}) begin
                     err <= 1'b1;
                  end
                  state <= pi_end ? DRAIN : IDLE;
               end
            end
            DRAIN: begin
               if (pixel_finish) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            FINISH: begin
               done <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sti_sched.sv
// Randomized scoreboard bench for sti_sched with requester and transmitter models.
module tb_sti_sched;

   localparam int TMO = 15;

   typedef struct {
      int          id;
      logic [15:0] data;
      logic [5:0]  cfg;
      logic        pend;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [1:0]  en;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [15:0] r0_data;
   logic [15:0] r1_data;
   logic [5:0]  r0_cfg;
   logic [5:0]  r1_cfg;
   logic        load;
   logic [15:0] pi_data;
   logic [1:0]  pi_length;
   logic        pi_fill;
   logic        pi_msb;
   logic        pi_low;
   logic        pi_end;
   logic        so_valid;
   logic        pixel_finish;
   logic        done;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   logic [21:0] q0[$];
   logic [21:0] q1[$];
   exp_t        exp_q[$];
   bit          gseen0 = 0;
   bit          gseen1 = 0;
   bit          tx_abort = 0;
   bit          tx_busy = 0;
   int          tx_skip = 0;
   int          tx_short = 0;

   sti_sched #(.START_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .req          (req),
      .gnt          (gnt),
      .r0_data      (r0_data),
      .r1_data      (r1_data),
      .r0_cfg       (r0_cfg),
      .r1_cfg       (r1_cfg),
      .load         (load),
      .pi_data      (pi_data),
      .pi_length    (pi_length),
      .pi_fill      (pi_fill),
      .pi_msb       (pi_msb),
      .pi_low       (pi_low),
      .pi_end       (pi_end),
      .so_valid     (so_valid),
      .pixel_finish (pixel_finish),
      .done         (done),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Requesters: hold the queue head until one cycle after its grant
   initial begin
      logic [21:0] w;
      req = 2'b00;
      r0_data = 16'h0; r1_data = 16'h0;
      r0_cfg = 6'h0; r1_cfg = 6'h0;
      forever begin
         @(negedge clk);
         if (gseen0 && q0.size() != 0) w = q0.pop_front();
         if (gseen1 && q1.size() != 0) w = q1.pop_front();
         gseen0 = gnt[0];
         gseen1 = gnt[1];
         req[0] = (q0.size() != 0);
         req[1] = (q1.size() != 0);
         w = req[0] ? q0[0] : 22'h0;
         r0_data = w[15:0]; r0_cfg = w[21:16];
         w = req[1] ? q1[0] : 22'h0;
         r1_data = w[15:0]; r1_cfg = w[21:16];
      end
   end

   task automatic run_tx();
      int   n;
      int   d;
      logic e;
      tx_busy = 1;
      n = (tx_short != 0) ? tx_short : 8 * (int'(pi_length) + 1);
      tx_short = 0;
      e = pi_end;
      d = $urandom_range(1, 4);
      repeat (d) begin
         @(negedge clk);
         if (tx_abort) begin tx_busy = 0; return; end
      end
      so_valid = 1;
      repeat (n) begin
         @(negedge clk);
         if (tx_abort) begin so_valid = 0; tx_busy = 0; return; end
      end
      so_valid = 0;
      if (e) begin
         repeat (2) @(negedge clk);
         pixel_finish = 1;
         @(negedge clk);
         pixel_finish = 0;
      end
      tx_busy = 0;
   endtask

   // Transmitter model
   initial begin
      so_valid = 0;
      pixel_finish = 0;
      forever begin
         @(negedge clk);
         if (load && !tx_abort) begin
            if (tx_skip > 0) tx_skip--;
            else run_tx();
         end
      end
   end

   // Monitor: grant order and loaded word against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && gnt != 2'b00) begin
            chk("gnt_onehot", 32'($onehot(gnt)), 1);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL gnt_unexpected actual=%0h expected=none", gnt);
            end else begin
               chk("gnt_order", gnt[1] ? 1 : 0, exp_q[0].id);
            end
         end
         if (reset && load) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL load_unexpected actual=%0h expected=none", pi_data);
            end else begin
               e = exp_q.pop_front();
               chk("pi_data", pi_data, e.data);
               chk("pi_ctrl", {pi_length, pi_fill, pi_msb, pi_low}, e.cfg[5:1]);
               chk("pi_end", pi_end, e.pend);
            end
         end
      end
   end

   // Word-level reference: round-robin over requesters with pending words
   task automatic build_exp(input logic [1:0] en_m);
      int          idx[2];
      bit          ended[2];
      int          last;
      int          p;
      bit          a0;
      bit          a1;
      logic [21:0] wd;
      exp_t        e;
      idx[0] = 0; idx[1] = 0;
      ended[0] = 0; ended[1] = 0;
      last = 1;
      while (1) begin
         a0 = en_m[0] && !ended[0] && idx[0] < q0.size();
         a1 = en_m[1] && !ended[1] && idx[1] < q1.size();
         if (!a0 && !a1) break;
         p = (a0 && a1) ? (last == 0 ? 1 : 0) : (a0 ? 0 : 1);
         wd = (p == 0) ? q0[idx[0]] : q1[idx[1]];
         idx[p]++;
         if (wd[16]) ended[p] = 1;
         e.id = p;
         e.data = wd[15:0];
         e.cfg = wd[21:16];
         e.pend = wd[16] && (!en_m[1 - p] || ended[1 - p]);
         exp_q.push_back(e);
         last = p;
      end
   endtask

   task automatic add_word(input int r, input logic [15:0] d,
                           input logic [1:0] len, input logic last);
      logic [2:0]  fb;
      logic [21:0] w;
      fb = 3'($urandom);
      w = {len, fb, last, d};
      if (r == 0) q0.push_back(w);
      else q1.push_back(w);
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      tx_abort = 1; reset = 0; en = 2'b00;
      q0.delete(); q1.delete(); exp_q.delete();
      gseen0 = 0; gseen1 = 0; tx_skip = 0; tx_short = 0;
      repeat (3) @(negedge clk);
      #2;
      tx_abort = 0; reset = 1;
   endtask

   task automatic wait_idle(input bit exp_done, input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || tx_busy || (exp_done && !done))
             && k < 3000) begin
         @(negedge clk); #3;
         k++;
      end
      chk({name, "_complete"}, k < 3000, 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic end_checks(input string name, input logic exp_err);
      chk({name, "_done"}, done, 1);
      chk({name, "_err"}, err, exp_err);
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int          k;
      int          n0;
      int          n1;
      bit          busy;
      logic [1:0]  em;
      reset = 0;
      en = 2'b00;
      #12;
      chk("rst_outs",
          {gnt, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, done, err},
          0);
      do_reset();

      // both requesters disabled: no activity at all
      en = 2'b00;
      add_word(0, 16'h1111, 0, 1);
      add_word(1, 16'h2222, 0, 1);
      busy = 0;
      repeat (30) begin
         @(negedge clk); #3;
         if (gnt != 2'b00 || load) busy = 1;
      end
      chk("dis_quiet", busy, 0);
      chk("dis_outs", {pi_data, done, err}, 0);

      // single requester, single end word
      do_reset();
      en = 2'b01;
      add_word(0, 16'hA5C3, 1, 1);
      build_exp(2'b01);
      wait_idle(1, "single");
      end_checks("single", 0);

      // both requesting continuously: strict alternation
      do_reset();
      en = 2'b11;
      for (int i = 0; i < 4; i++) begin
         add_word(0, 16'($urandom), 0, i == 3);
         add_word(1, 16'($urandom), 0, i == 3);
      end
      build_exp(2'b11);
      wait_idle(1, "alt");
      end_checks("alt", 0);

      // short bit count on a 32-bit word, next word still granted
      do_reset();
      en = 2'b01;
      add_word(0, 16'($urandom), 3, 0);
      add_word(0, 16'($urandom), 0, 1);
      build_exp(2'b01);
      tx_short = 24;
      wait_idle(1, "badcnt");
      end_checks("badcnt", 1);

      // transmitter never starts: timeout then resume
      do_reset();
      en = 2'b01;
      add_word(0, 16'($urandom), 0, 0);
      add_word(0, 16'($urandom), 0, 1);
      build_exp(2'b01);
      tx_skip = 1;
      k = 0;
      while (!load && k < 200) begin @(negedge clk); #3; k++; end
      chk("tmo_load_seen", k < 200, 1);
      k = 0;
      while (!err && k < 40) begin @(negedge clk); #3; k++; end
      chk("tmo_cycles", k, TMO);
      wait_idle(1, "tmo");
      end_checks("tmo", 1);

      // reset in the middle of a 32-bit shift
      do_reset();
      en = 2'b01;
      add_word(0, 16'h1234, 3, 1);
      build_exp(2'b01);
      k = 0;
      while (!so_valid && k < 200) begin @(negedge clk); #3; k++; end
      chk("mid_shift_seen", k < 200, 1);
      repeat (10) @(negedge clk);
      #2; reset = 0; #1;
      chk("mid_rst_outs",
          {gnt, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, done, err},
          0);
      do_reset();
      en = 2'b11;
      add_word(0, 16'($urandom), 2, 1);
      add_word(1, 16'($urandom), 1, 1);
      build_exp(2'b11);
      wait_idle(1, "post_rst");
      end_checks("post_rst", 0);

      // randomized streams, disabled requester may still raise req
      for (int it = 0; it < 6; it++) begin
         do_reset();
         k = $urandom_range(1, 3);
         em = 2'(k);
         en = em;
         n0 = $urandom_range(1, 4);
         n1 = $urandom_range(1, 4);
         for (int i = 0; i < n0; i++)
            add_word(0, 16'($urandom), 2'($urandom), i == n0 - 1);
         for (int i = 0; i < n1; i++)
            add_word(1, 16'($urandom), 2'($urandom), i == n1 - 1);
         build_exp(em);
         wait_idle(1, "rand");
         end_checks("rand", 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
